mux_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one registered 3:1 bit-select datapath among three requesters (A, B, C).
- Arbitrates requests and grants one requester at a time for a bounded burst.
- Drives the datapath's select/enable and contains the registered output stage, so the block is self-contained.
- Sits between requesting agents and the downstream consumer of z.

---
 rtl/mux_sched_pkg.sv | 36 +++
 rtl/mux_rr_scheduler_rr_pick.sv | 53 +++++
 rtl/mux_rr_scheduler.sv | 157 +++++++++++++++
 tb/tb_mux_rr_scheduler.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mux_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_sched_pkg
// Description : Shared types, select encodings and helpers for the
//               round-robin 3:1 datapath scheduler.
// Revision    : 1.0  initial release
// ============================================================================
package mux_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Datapath select encodings; SEL_NONE never loads the output register
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_C    = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  // Map a one-hot (or zero) grant vector onto the datapath select code
  function automatic logic [1:0] gnt_to_sel(input logic [2:0] g);
    logic [1:0] s;
    s = SEL_NONE;
    case (g)
      3'b001:  s = SEL_A;
      3'b010:  s = SEL_B;
      3'b100:  s = SEL_C;
      default: s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage : mux_sched_pkg
`default_nettype wire

// File: rtl/mux_rr_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker for three requesters.
//               Scans circularly starting at the requester after `last_i`
//               (A->B->C->A), ignoring any bit set in `exclude_i`. The
//               previous owner therefore naturally ends up lowest priority.
// Revision    : 1.0  initial release
// ============================================================================
module rr_pick
  import mux_sched_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] last_i,
  input  logic [2:0] exclude_i,
  output logic [2:0] winner_o,
  output logic       valid_o
);

  logic [2:0] w_cand;
  logic [2:0] w_rot;
  logic [2:0] w_first;

  assign w_cand  = req_i & ~exclude_i;
  assign valid_o = |w_cand;

  // Rotate candidates so bit0 is the requester right after `last`
  always_comb begin
    w_rot = w_cand;
    case (last_i)
      SEL_A:   w_rot = {w_cand[0], w_cand[2], w_cand[1]};  // order B,C,A
      SEL_B:   w_rot = {w_cand[1], w_cand[0], w_cand[2]};  // order C,A,B
      default: w_rot = w_cand;                             // order A,B,C
    endcase
  end

  // Fixed-priority first-set on the rotated vector
  assign w_first[0] = w_rot[0];
  assign w_first[1] = w_rot[1] & ~w_rot[0];
  assign w_first[2] = w_rot[2] & ~w_rot[1] & ~w_rot[0];

  // Undo the rotation to return a one-hot winner in A/B/C bit positions
  always_comb begin
    winner_o = w_first;
    case (last_i)
      SEL_A:   winner_o = {w_first[1], w_first[0], w_first[2]};
      SEL_B:   winner_o = {w_first[0], w_first[2], w_first[1]};
      default: winner_o = w_first;
    endcase
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mux_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_scheduler
// Description : Round-robin scheduler sharing one registered 3:1 bit-select
//               datapath among requesters A, B and C. Grants are held for at
//               most BURST_LEN consecutive cycles, then rotate without an idle
//               bubble. Contains the registered output stage z.
//               Optional build macro MUX_SCHED_LOCK_EN adds a `lock` input
//               that lets the current owner hold its grant past BURST_LEN.
// Revision    : 1.0  initial release
// ============================================================================
module mux_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       a,
  input  logic       b,
  input  logic       c,
`ifdef MUX_SCHED_LOCK_EN
  input  logic       lock,
`endif
  output logic [2:0] gnt,
  output logic [1:0] sel,
  output logic       enable,
  output logic       z,
  output logic       busy
);

  localparam logic [CNT_W-1:0] c_BURST_MAX = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [2:0]       gnt_q,   gnt_d;
  logic [1:0]       last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             z_q;

  logic [2:0]       w_winner;
  logic             w_valid;
  logic [2:0]       w_exclude;
  logic             w_owner_req;
  logic             w_at_limit;
  logic             w_lock_hold;
  logic             w_release;
  logic             w_data;

  // Owner still requesting? (gnt_q is one-hot or zero)
  assign w_owner_req = |(req & gnt_q);
  // An owner that dropped its request is never re-picked in the same cycle
  assign w_exclude   = gnt_q & ~req;
  assign w_at_limit  = (cnt_q == c_BURST_MAX);

`ifdef MUX_SCHED_LOCK_EN
  assign w_lock_hold = lock & w_owner_req;
`else
  assign w_lock_hold = 1'b0;
`endif

  assign w_release = ~w_owner_req | (w_at_limit & ~w_lock_hold);

  // last_q always names the current owner while in GRANT, so the same scan
  // origin works for both the idle pick and the hand-over pick.
  rr_pick u_rr_pick (
    .req_i     (req),
    .last_i    (last_q),
    .exclude_i (w_exclude),
    .winner_o  (w_winner),
    .valid_o   (w_valid)
  );

  // Next-state logic for FSM, grant, pointer and burst counter
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (w_valid) begin
          state_d = GRANT;
          gnt_d   = w_winner;
          last_d  = gnt_to_sel(w_winner);
          cnt_d   = c_CNT_ONE;
        end
      end
      GRANT: begin
        if (!w_release) begin
          // Saturate at the limit while a lock holds the grant
          if (!w_at_limit) begin
            cnt_d = cnt_q + c_CNT_ONE;
          end
        end else if (w_valid) begin
          gnt_d  = w_winner;
          last_d = gnt_to_sel(w_winner);
          cnt_d  = c_CNT_ONE;
        end else begin
          state_d = IDLE;
          gnt_d   = 3'b000;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
        cnt_d   = '0;
      end
    endcase
  end

  // Scheduler state registers; reset points the pointer at C so A wins first
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= 3'b000;
      last_q  <= SEL_C;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel    = gnt_to_sel(gnt_q);
  assign enable = |gnt_q;
  assign busy   = (state_q == GRANT);
  assign gnt    = gnt_q;
  assign z      = z_q;

  // Datapath 3:1 bit select driven by the current select code
  always_comb begin
    w_data = 1'b0;
    case (sel)
      SEL_A:   w_data = a;
      SEL_B:   w_data = b;
      SEL_C:   w_data = c;
      default: w_data = 1'b0;
    endcase
  end

  // Registered output stage; holds its value whenever nothing is granted
  always_ff @(posedge clk) begin
    if (!rst) begin
      z_q <= 1'b0;
    end else if (enable) begin
      z_q <= w_data;
    end
  end

endmodule : mux_rr_scheduler
`default_nettype wire

// File: tb/tb_mux_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_scheduler
// Description : Self-checking bench for mux_rr_scheduler. Directed scenarios
//               followed by randomized traffic, compared cycle by cycle with
//               a behavioural round-robin model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mux_rr_scheduler;

  localparam int BURST_LEN = 4;
`ifdef MUX_SCHED_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic       a, b, c;
  logic       lock_r;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       enable;
  logic       z;
  logic       busy;

  int n_checks;
  int n_pass;

  // Behavioural model: owner index (-1 = idle), burst length so far,
  // index of the last granted requester, and the output bit.
  int m_own;
  int m_cnt;
  int m_last;
  bit m_z;

  mux_rr_scheduler #(.BURST_LEN(BURST_LEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .a      (a),
    .b      (b),
    .c      (c),
`ifdef MUX_SCHED_LOCK_EN
    .lock   (lock_r),
`endif
    .gnt    (gnt),
    .sel    (sel),
    .enable (enable),
    .z      (z),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // First requester found scanning circularly after index `from`
  function automatic int rr_next(input logic [2:0] rq, input int from);
    for (int i = 1; i <= 3; i++) begin
      int j;
      j = (from + i) % 3;
      if (rq[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [2:0] rq,
                            input logic [2:0] d, input logic lk);
    int w;
    bit keep;
    if (!r) begin
      m_own = -1; m_cnt = 0; m_last = 2; m_z = 1'b0;
    end else begin
      if (m_own >= 0) m_z = d[m_own];
      if (m_own < 0) begin
        w = rr_next(rq, m_last);
        if (w >= 0) begin m_own = w; m_cnt = 1; m_last = w; end
      end else begin
        keep = rq[m_own] && ((m_cnt < BURST_LEN) || (LOCK_EN && lk));
        if (keep) begin
          if (m_cnt < BURST_LEN) m_cnt++;
        end else begin
          w = rr_next(rq, m_own);
          if (w >= 0) begin m_own = w; m_cnt = 1; m_last = w; end
          else begin m_own = -1; m_cnt = 0; end
        end
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("gnt",    32'(gnt),    (m_own < 0) ? 32'd0 : (32'd1 << m_own));
    check_eq("sel",    32'(sel),    (m_own < 0) ? 32'd3 : 32'(m_own));
    check_eq("enable", 32'(enable), 32'(m_own >= 0));
    check_eq("busy",   32'(busy),   32'(m_own >= 0));
    check_eq("z",      32'(z),      32'(m_z));
  endtask

  // One clock: drive on the falling edge, model the rising edge, sample after
  task automatic cyc(input logic r, input logic [2:0] rq, input logic [2:0] d, input logic lk);
    @(negedge clk);
    rst = r; req = rq; {c, b, a} = d; lock_r = lk;
    @(posedge clk);
    model_step(r, rq, d, lk);
    #1;
    check_outputs();
  endtask

  initial begin
    logic [2:0] rq;
    logic       r;
    logic       lk;
    clk = 1'b0; rst = 1'b0; req = 3'b000; a = 1'b0; b = 1'b0; c = 1'b0; lock_r = 1'b0;
    n_checks = 0; n_pass = 0;
    m_own = -1; m_cnt = 0; m_last = 2; m_z = 1'b0;

    // Reset with all requesting, then A,B,C,A bursts of 4 with no gaps
    cyc(1'b0, 3'b111, 3'b111, 1'b0);
    cyc(1'b0, 3'b111, 3'b111, 1'b0);
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_sel", 32'(sel), 32'd3);
    check_eq("rst_z",   32'(z),   32'd0);
    cyc(1'b1, 3'b111, 3'b101, 1'b0);
    check_eq("first_is_A", 32'(gnt), 32'd1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 3'b111, 3'b101, 1'b0);
    check_eq("then_B", 32'(gnt), 32'd2);
    for (int i = 0; i < 12; i++) cyc(1'b1, 3'b111, 3'(i), 1'b0);

    // Sole requester B with b=1 is re-granted back to back
    cyc(1'b0, 3'b000, 3'b000, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 3'b010, 3'b010, 1'b0);
    check_eq("sole_B_held", 32'(gnt), 32'd2);
    check_eq("sole_B_z",    32'(z),   32'd1);

    // Early release of A hands over to C
    cyc(1'b0, 3'b000, 3'b000, 1'b0);
    cyc(1'b1, 3'b101, 3'b001, 1'b0);
    cyc(1'b1, 3'b101, 3'b001, 1'b0);
    cyc(1'b1, 3'b100, 3'b001, 1'b0);
    check_eq("early_to_C", 32'(gnt), 32'd4);

    // Return to idle; data toggles must not disturb z
    cyc(1'b1, 3'b000, 3'b100, 1'b0);
    check_eq("idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 3'b000, 3'(i + 1), 1'b0);

    // Reset mid-burst of B, then B wins first again from req=110
    cyc(1'b1, 3'b010, 3'b010, 1'b0);
    cyc(1'b1, 3'b010, 3'b010, 1'b0);
    cyc(1'b0, 3'b010, 3'b010, 1'b0);
    check_eq("midrst_gnt", 32'(gnt), 32'd0);
    cyc(1'b1, 3'b110, 3'b000, 1'b0);
    check_eq("post_rst_B", 32'(gnt), 32'd2);
    for (int i = 0; i < 6; i++) cyc(1'b1, 3'b110, 3'b110, 1'b0);

    // Lock holds A past the burst limit; model covers both builds
    cyc(1'b0, 3'b000, 3'b000, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b1, 3'b011, 3'b001, 1'b1);
    cyc(1'b1, 3'b011, 3'b001, 1'b0);
    cyc(1'b1, 3'b011, 3'b001, 1'b0);

    // Randomized traffic with occasional resets and lock activity
    rq = 3'b000;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 99) < 30) rq = 3'($urandom_range(0, 7));
      lk = ($urandom_range(0, 3) == 0);
      cyc(r, rq, 3'($urandom_range(0, 7)), lk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mux_rr_scheduler
`default_nettype wire
